// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by `define MDU_MADD_EN.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW         = 2 * WIDTH;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic             accept, mt_hi, mt_lo, last_cycle, busy_next, done_next;
  logic [CW-1:0]    cnt_load;
  logic [DW-1:0]    result;
  logic             res_valid;

  // Multiply-class ops, including accumulate variants when enabled
  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (is_mul_op(md_op) || is_div_op(md_op))) state_next = RUN;
      RUN:  if (cnt == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes; starts of any kind are only honoured in IDLE
  always_comb begin
    accept     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    last_cycle = 1'b0;
    cnt_load   = CW'(MULT_CYCLES);
    if (is_div_op(md_op)) cnt_load = CW'(DIV_CYCLES);
    if (state == IDLE && start) begin
      accept = is_mul_op(md_op) || is_div_op(md_op);
      mt_hi  = (md_op == OP_MTHI);
      mt_lo  = (md_op == OP_MTLO);
    end
    if (state == RUN && cnt == CW'(1)) last_cycle = 1'b1;
    busy_next = (state_next == RUN);
    done_next = last_cycle;
  end

  // Product of the latched operands, sign-extended for the signed flavours
  logic          signed_mul;
  logic [DW-1:0] a_ext, b_ext, product;

  always_comb begin
    signed_mul = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
    signed_mul = signed_mul || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    a_ext   = signed_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = signed_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;
  end

  // Divisor forced to 1 for div-by-zero (result discarded) and MIN/-1,
  // where MIN/1 already yields the required quotient MIN, remainder 0.
  logic                    div_ovf, div_zero;
  logic [WIDTH-1:0]        b_div, udiv_q, udiv_r;
  logic signed [WIDTH-1:0] sdiv_a, sdiv_b, sdiv_q, sdiv_r;

  always_comb begin
    div_zero = (b_q == '0);
    div_ovf  = (op_q == OP_DIV) && (a_q == MIN_NEG) && (&b_q);
    b_div    = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
    udiv_q   = a_q / b_div;
    udiv_r   = a_q % b_div;
    sdiv_a   = a_q;
    sdiv_b   = b_div;
    sdiv_q   = sdiv_a / sdiv_b;
    sdiv_r   = sdiv_a % sdiv_b;
  end

  // Value committed to {hi,lo} on the last RUN cycle
  always_comb begin
    result    = {hi, lo};
    res_valid = 1'b1;
    case (op_q)
      OP_MULT, OP_MULTU: result = product;
      OP_DIV: begin
        res_valid = !div_zero;
        result    = {$unsigned(sdiv_r), $unsigned(sdiv_q)};
      end
      OP_DIVU: begin
        res_valid = !div_zero;
        result    = {udiv_r, udiv_q};
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: result = {hi, lo} + product;
      OP_MSUB, OP_MSUBU: result = {hi, lo} - product;
`endif
      default: res_valid = 1'b0;
    endcase
  end

  // Operand capture, counter, HI/LO and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (accept) begin
        op_q <= md_op;
        a_q  <= inputA;
        b_q  <= inputB;
        cnt  <= cnt_load;
      end else if (state == RUN) begin
        cnt  <= cnt - CW'(1);
      end
      if (mt_hi) hi <= inputA;
      if (mt_lo) lo <= inputA;
      if (last_cycle && res_valid) begin
        hi <= result[DW-1:WIDTH];
        lo <= result[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default 32-bit, 5/10-cycle latencies).
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] inputA, inputB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int fails  = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .inputA(inputA), .inputB(inputB),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, then scramble operands to prove they were latched
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; inputA = a; inputB = b;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0; inputA = 32'hDEAD_BEEF; inputB = 32'h0;
  endtask

  // Count busy cycles; exits in the first cycle with busy low (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; md_op = 4'd0; inputA = '0; inputB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    checks++; if (n !== 5) begin fails++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL mult_done: got %b expected 1", done); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_multu();
    int n;
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (n !== 5) begin fails++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++; if (n !== 10) begin fails++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL div_done: got %b expected 1", done); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
    issue(4'd4, 32'd100, 32'd7);
    wait_idle(n);
    checks++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_mt_divzero();
    int n;
    start = 1'b1; md_op = 4'd5; inputA = 32'h1234;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    md_op = 4'd6; inputA = 32'h5678;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
    checks++; if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo_lo: got %h expected 00005678", lo); end
    issue(4'd4, 32'd99, 32'd0);
    wait_idle(n);
    checks++; if (n !== 10) begin fails++; $display("FAIL div0_busy_cycles: got %0d expected 10", n); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL div0_done: got %b expected 1", done); end
    checks++; if (hi !== 32'h1234) begin fails++; $display("FAIL div0_hi: got %h expected 00001234", hi); end
    checks++; if (lo !== 32'h5678) begin fails++; $display("FAIL div0_lo: got %h expected 00005678", lo); end
  endtask

  task automatic test_abort();
    int seen_done = 0;
    int seen_busy = 0;
    issue(4'd1, 32'd5, 32'd7);
    start = 1'b1; md_op = 4'd6; inputA = 32'hAA;
    @(negedge clk);
    md_op = 4'd1; inputA = 32'd2; inputB = 32'd2;
    checks++; if (lo !== 32'h5678) begin fails++; $display("FAIL busy_mtlo_ignored: got %h expected 00005678", lo); end
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin fails++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    repeat (12) begin
      if (done === 1'b1) seen_done++;
      if (busy === 1'b1) seen_busy++;
      @(negedge clk);
    end
    checks++; if (seen_done !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
    checks++; if (seen_busy !== 0) begin fails++; $display("FAIL abort_no_busy: got %0d cycles expected 0", seen_busy); end
  endtask

  task automatic test_madd();
    int n;
    start = 1'b1; md_op = 4'd5; inputA = 32'h0;
    @(negedge clk);
    md_op = 4'd6; inputA = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(n);
    checks++; if (n !== 5) begin fails++; $display("FAIL maddu_busy_cycles: got %0d expected 5", n); end
    checks++; if (hi !== 32'd1) begin fails++; $display("FAIL maddu_hi: got %h expected 00000001", hi); end
    checks++; if (lo !== 32'd0) begin fails++; $display("FAIL maddu_lo: got %h expected 00000000", lo); end
    issue(4'd9, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    checks++; if (hi !== 32'd1) begin fails++; $display("FAIL msub_hi: got %h expected 00000001", hi); end
    checks++; if (lo !== 32'd6) begin fails++; $display("FAIL msub_lo: got %h expected 00000006", lo); end
`else
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL maddu_nop_busy: got %b expected 0", busy); end
    repeat (6) @(negedge clk);
    n = 0;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL maddu_nop_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL maddu_nop_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL maddu_nop_lo: got %h expected ffffffff", lo); end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd12, 32'd3, 32'd4);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL nop_busy: got %b expected 0", busy); end
    issue(4'd1, 32'd6, 32'd7);
    wait_idle(n);
    checks++; if (lo !== 32'd42) begin fails++; $display("FAIL b2b_mult_lo: got %h expected 0000002a", lo); end
    issue(4'd4, 32'd42, 32'd5);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_vs_busy: got %b expected 0", done); end
    wait_idle(n);
    checks++; if (n !== 10) begin fails++; $display("FAIL b2b_div_cycles: got %0d expected 10", n); end
    checks++; if (lo !== 32'd8) begin fails++; $display("FAIL b2b_divu_lo: got %h expected 00000008", lo); end
    checks++; if (hi !== 32'd2) begin fails++; $display("FAIL b2b_divu_hi: got %h expected 00000002", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mt_divzero();
    test_abort();
    test_madd();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
